// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit.
// FSM encoding, RV32I funct3 width codes and request legality check.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // 1 when the code is illegal for the direction or the address is misaligned
  function automatic logic lsu_bad(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = !a[0];
      F3_W:    ok = (a == 2'b00);
      F3_BU:   ok = !we;
      F3_HU:   ok = !we && !a[0];
      default: ok = 1'b0;
    endcase
    return !ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extract (loads) and lane merge (sub-word stores).
// Purely combinational; fed by the captured read word.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [4:0]  w_bsh;
  logic [4:0]  w_hsh;
  logic [31:0] w_bmask;
  logic [31:0] w_hmask;
  logic [31:0] w_bdat;
  logic [31:0] w_hdat;

  assign w_bsh   = {i_off, 3'b000};
  assign w_hsh   = {i_off[1], 4'b0000};
  assign w_bmask = 32'h0000_00ff << w_bsh;
  assign w_hmask = 32'h0000_ffff << w_hsh;
  assign w_bdat  = {24'b0, i_wdata[7:0]} << w_bsh;
  assign w_hdat  = {16'b0, i_wdata[15:0]} << w_hsh;
  assign w_half  = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

  // select the addressed byte lane
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_off)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  // sign/zero extend the selected lane for loads
  always_comb begin
    o_load = '0;
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load = {24'b0, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load = {16'b0, w_half};
      F3_W:    o_load = i_rdata;
      default: o_load = '0;
    endcase
  end

  // replace only the addressed lanes of the read word
  always_comb begin
    o_merge = i_wdata;
    case (i_funct3[1:0])
      2'b00:   o_merge = (i_rdata & ~w_bmask) | w_bdat;
      2'b01:   o_merge = (i_rdata & ~w_hmask) | w_hdat;
      default: o_merge = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit against a word-wide, async-read data memory.
// Sub-word stores use read-modify-write; bad requests answer at once.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  state_t            r_state;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic [31:0]       r_wdata;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wd;
  logic              w_bad;
  logic [31:0]       w_load;
  logic [31:0]       w_merge;

  assign w_bad     = lsu_bad(req_we, req_funct3, req_addr[1:0]);
  assign req_ready = (r_state == IDLE) && !rst;
  assign mem_we    = (r_state == WRITE) && !rst;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_addr  = r_mem_addr;
  assign mem_wd    = r_mem_wd;

  lsu_align u_align (
    .i_funct3 (r_funct3),
    .i_off    (r_off),
    .i_rdata  (mem_rd),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  // request FSM with registered response and memory outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_funct3    <= '0;
      r_off       <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wd    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_off    <= req_addr[1:0];
            r_wdata  <= req_wdata;
            if (w_bad) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else begin
              r_mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
              if (req_we && (req_funct3 == F3_W)) begin
                r_state  <= WRITE;
                r_mem_wd <= req_wdata;
              end else begin
                r_state <= READ;
              end
            end
          end
        end
        READ: begin
          if (r_we) begin
            r_state  <= WRITE;
            r_mem_wd <= w_merge;
          end else begin
            r_state     <= RESP;
            r_mem_addr  <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= w_load;
          end
        end
        WRITE: begin
          r_state     <= RESP;
          r_mem_addr  <= '0;
          r_mem_wd    <= '0;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
        end
        RESP: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word memory model.
// Checks latency, extraction, RMW merge, errors, reset abort, spacing.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:16383];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          we_cnt  = 0;
  int          rsp_cnt = 0;
  logic [31:0] last_wd = '0;

  load_store_unit #(.ADDR_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr[15:2]];

  always @(posedge clk)
    if (mem_we) mem[mem_addr[15:2]] <= mem_wd;

  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt  <= we_cnt + 1;
      last_wd <= mem_wd;
    end
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic we, input logic [2:0] f3,
                      input logic [15:0] a, input logic [31:0] wd);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output logic [31:0] rd,
                          output logic err);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 10);
    rd  = rsp_rdata;
    err = rsp_err;
    #1;
  endtask

  task automatic xact(input string tag, input logic we,
                      input logic [2:0] f3, input logic [15:0] a,
                      input logic [31:0] wd, input int elat,
                      input logic [31:0] erd, input logic eerr);
    int          lat;
    logic [31:0] rd;
    logic        err;
    send(we, f3, a, wd);
    wait_rsp(lat, rd, err);
    chk({tag, ".lat"}, 32'(lat), 32'(elat));
    chk({tag, ".rdata"}, rd, erd);
    chk({tag, ".err"}, 32'(err), 32'(eerr));
  endtask

  initial begin
    int w0;
    int r0;
    int acc;
    int rsps;
    int errs;
    int last;
    int mgap;

    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = '0;
    req_addr = '0;
    req_wdata = '0;
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    mem[16'h0040 >> 2] = 32'h8899aabb;

    repeat (2) @(negedge clk);
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post.ready", 32'(req_ready), 32'd1);
    chk("post.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post.rsp_rdata", rsp_rdata, 32'd0);
    chk("post.rsp_err", 32'(rsp_err), 32'd0);
    chk("post.mem_addr", 32'(mem_addr), 32'd0);
    chk("post.mem_wd", mem_wd, 32'd0);

    xact("lb41", 1'b0, F3_B, 16'h0041, 0, 2, 32'hffffffaa, 1'b0);
    xact("lhu42", 1'b0, F3_HU, 16'h0042, 0, 2, 32'h00008899, 1'b0);
    xact("lw40", 1'b0, F3_W, 16'h0040, 0, 2, 32'h8899aabb, 1'b0);
    xact("lh42", 1'b0, F3_H, 16'h0042, 0, 2, 32'hffff8899, 1'b0);
    xact("lbu41", 1'b0, F3_BU, 16'h0041, 0, 2, 32'h000000aa, 1'b0);
    xact("lb40", 1'b0, F3_B, 16'h0040, 0, 2, 32'hffffffbb, 1'b0);
    xact("lbu43", 1'b0, F3_BU, 16'h0043, 0, 2, 32'h00000088, 1'b0);

    w0 = we_cnt;
    xact("sb43", 1'b1, F3_B, 16'h0043, 32'h12345677, 3, 32'd0, 1'b0);
    chk("sb43.pulses", 32'(we_cnt - w0), 32'd1);
    chk("sb43.wd", last_wd, 32'h7799aabb);
    chk("sb43.mem", mem[16'h0040 >> 2], 32'h7799aabb);

    w0 = we_cnt;
    xact("lw42", 1'b0, F3_W, 16'h0042, 0, 1, 32'd0, 1'b1);
    xact("sh41", 1'b1, F3_H, 16'h0041, 32'h0000cafe, 1, 32'd0, 1'b1);
    xact("ld011", 1'b0, 3'b011, 16'h0040, 0, 1, 32'd0, 1'b1);
    xact("st100", 1'b1, 3'b100, 16'h0040, 0, 1, 32'd0, 1'b1);
    xact("lhu43", 1'b0, F3_HU, 16'h0043, 0, 1, 32'd0, 1'b1);
    chk("err.no_we", 32'(we_cnt - w0), 32'd0);

    xact("sw44", 1'b1, F3_W, 16'h0044, 32'hdeadbeef, 2, 32'd0, 1'b0);
    chk("sw44.mem", mem[16'h0044 >> 2], 32'hdeadbeef);
    xact("sh46", 1'b1, F3_H, 16'h0046, 32'h0000cafe, 3, 32'd0, 1'b0);
    chk("sh46.mem", mem[16'h0044 >> 2], 32'hcafebeef);

    w0 = we_cnt;
    r0 = rsp_cnt;
    send(1'b1, F3_H, 16'h0040, 32'h0000cafe);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstw.ready", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);
    #1;
    chk("rstw.no_rsp", 32'(rsp_cnt - r0), 32'd0);
    chk("rstw.no_we", 32'(we_cnt - w0), 32'd0);
    chk("rstw.mem", mem[16'h0040 >> 2], 32'h7799aabb);

    acc = 0;
    rsps = 0;
    errs = 0;
    last = -100;
    mgap = 1000;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = F3_W;
    req_addr   = 16'h0044;
    req_wdata  = '0;
    for (int i = 0; i < 15; i++) begin
      if (req_valid && req_ready) begin
        acc++;
        if (i - last < mgap) mgap = i - last;
        last = i;
      end
      if (rsp_valid) begin
        rsps++;
        if (rsp_err || rsp_rdata !== 32'hcafebeef) errs++;
      end
      if (i == 11) req_valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b.accepts", 32'(acc), 32'd4);
    chk("b2b.rsps", 32'(rsps), 32'(acc));
    chk("b2b.gap", 32'(mgap), 32'd3);
    chk("b2b.bad_rsp", 32'(errs), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the byte-address width of the request and memory ports.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 req_valid  input  1  SHALL mark a valid load/store request.
REQ-005 req_ready  output  1  SHALL mark that the unit accepts a request this cycle.
REQ-006 req_we  input  1  SHALL select store (1) or load (0).
REQ-007 req_funct3  input  3  SHALL carry the RV32I width/sign code.
REQ-008 req_addr  input  ADDR_W  SHALL carry the byte address.
REQ-009 req_wdata  input  32  SHALL carry store data, right-aligned.
REQ-010 rsp_valid  output  1  SHALL pulse one cycle when a request completes.
REQ-011 rsp_rdata  output  32  SHALL carry extended load data; zero for stores and errors.
REQ-012 rsp_err  output  1  SHALL flag misaligned or illegal requests, valid with rsp_valid.
REQ-013 mem_we  output  1  SHALL be the word write enable to data memory.
REQ-014 mem_addr  output  ADDR_W  SHALL be the word-aligned byte address, bits [1:0] always 0.
REQ-015 mem_wd  output  32  SHALL be the full write word.
REQ-016 mem_rd  input  32  SHALL be the combinational read word for mem_addr, valid in the same cycle.

Function
REQ-017 The FSM SHALL use the states IDLE, READ, WRITE and RESP.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready, and all request fields are registered.
REQ-019 Loads SHALL follow IDLE->READ->RESP, with mem_rd sampled at the end of READ and rsp_valid 2 cycles after acceptance.
REQ-020 SW SHALL follow IDLE->WRITE->RESP, with mem_we=1 for exactly the WRITE cycle and mem_wd=req_wdata.
REQ-021 SB/SH SHALL follow IDLE->READ->WRITE->RESP as a read-modify-write.
- mem_wd = the captured read word with only the addressed lanes replaced (byte lane addr[1:0]; half lane addr[1]).
- rsp_valid 3 cycles after acceptance.
REQ-022 Load extraction SHALL be as follows.
- LB/LH: sign-extend the addressed byte or half.
- LBU/LHU: zero-extend it.
- LW: whole word.
REQ-023 Accepted funct3 codes: loads 000,001,010,100,101; stores 000,001,010.
REQ-024 Any other code SHALL give IDLE->RESP with rsp_err=1.
REQ-025 Misalignment SHALL give IDLE->RESP with rsp_err=1 and no memory access.
- Halfword access with addr[0]=1.
- Word access with addr[1:0]!=0.
REQ-026 RESP SHALL last one cycle and return to IDLE.
- req_ready stays 0 during RESP, so back-to-back requests are spaced by at least one IDLE cycle.
- There is no response backpressure.
REQ-027 mem_we SHALL be 0 in every state except WRITE and SHALL be gated by !rst, so no write occurs in a reset cycle.
REQ-028 mem_addr SHALL be {addr[ADDR_W-1:2],2'b00} of the registered request in READ/WRITE and 0 otherwise.
REQ-029 mem_wd SHALL be 0 outside WRITE.

Reset
REQ-030 While rst=1 at a clock edge, the FSM SHALL enter IDLE and every output register SHALL clear.
- Cleared: rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wd.
REQ-031 req_ready SHALL be 0 during reset cycles and 1 in the first cycle after rst deasserts.
REQ-032 A reset during READ or WRITE SHALL abandon the request.
- No response is issued.
- No partial write reaches memory.

Structure
REQ-033 A shared header SHALL hold the FSM state encodings and the funct3 constants.
- FSM states: IDLE=0, READ=1, WRITE=2, RESP=3.
- funct3: F3_B, F3_H, F3_W, F3_BU, F3_HU.
REQ-034 Lane extract/merge logic SHALL be a combinational sub-module lsu_align, shared by the load and RMW paths.
REQ-035 The unit SHALL connect to the data-memory ports: mem_we->we, mem_addr->addr, mem_wd->wd, mem_rd<-rd.

Verification
REQ-036 Memory word 0x40 = 0x8899AABB; LB addr 0x41 -> rsp_valid at +2 cycles, rsp_rdata=0xFFFFFFAA, rsp_err=0.
REQ-037 Same word; LHU addr 0x42 -> rsp_rdata=0x00008899; LW addr 0x40 -> 0x8899AABB.
REQ-038 SB addr 0x43 wdata 0x12345677 -> one READ, then one mem_we pulse with mem_wd=0x7799AABB; response at +3 cycles.
REQ-039 LW addr 0x42 and SH addr 0x41 -> rsp_err=1 at +1 cycle, mem_we never asserted; funct3=011 load -> rsp_err=1.
REQ-040 SH addr 0x40 wdata 0xCAFE, rst pulsed in the WRITE cycle -> memory word unchanged, no rsp_valid, req_ready=1 one cycle after rst drops.
REQ-041 Back-to-back requests with req_valid held high -> acceptances spaced ≥1 IDLE cycle apart, each yields exactly one rsp_valid pulse.
